// File: rtl/clb_config_loader_if.sv
// ----------------------------------------------------------------------------
// clb_config_loader_if
// Byte handshake between the bitstream source and the CLB configuration
// loader.
//   byte_valid : source -> loader, byte_data holds a bitstream byte
//   byte_data  : source -> loader, bitstream byte (MSB is shifted first)
//   byte_ready : loader -> source, loader can accept a byte this cycle
// A byte transfers on a rising clock edge where byte_valid && byte_ready.
// ----------------------------------------------------------------------------
interface clb_config_loader_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready
    );
endinterface

// File: rtl/clb_config_loader.sv
// ----------------------------------------------------------------------------
// clb_config_loader
// Serial configuration sequencer in front of the SLICEM LUT shift chain.
// Accepts bitstream bytes over a valid/ready handshake and shifts them
// MSB-first onto the LUT configuration chain. It frames the stream into
// FRAME_BITS-bit frames, one per LUT in index order, strobes the matching
// one-hot CLB_prgm_b bit, and raises prgm_b/GWE/done once every frame has
// been shifted.
//
// Optional feature macro: CFG_LOADER_PARITY_EN
//   When defined, every emitted bit is XOR-accumulated. After the last frame
//   the loader accepts one trailing byte whose bit0 must equal that XOR: a
//   match goes to DONE, a mismatch raises error. When undefined there is no
//   trailing byte and error is tied low.
//
// Ports:
//   CLK             : clock, rising edge
//   reset           : asynchronous, active-high reset
//   start           : single-cycle pulse that begins a load
//   bus             : byte handshake (slave side: byte_valid, byte_data in,
//                     byte_ready out)
//   config_data_out : serial bit to the LUT config_data_in
//   shift_en        : config_data_out is valid this cycle
//   CLB_prgm_b      : one-hot, bit i high while LUT i is being shifted
//   prgm_b          : 0 while configuring, 1 in operate mode
//   GWE             : global write enable, follows prgm_b
//   lut_idx         : index of the LUT currently being loaded
//   done            : load complete
//   error           : trailing parity check failed
// All outputs are flops. Each output flop is loaded with the value that
// belongs to the state being entered, so outputs line up with state_q.
// ----------------------------------------------------------------------------
module clb_config_loader #(
    parameter int NUM_LUTS   = 4,
    parameter int FRAME_BITS = 38
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      start,
    clb_config_loader_if.slave        bus,
    output logic                      config_data_out,
    output logic                      shift_en,
    output logic [NUM_LUTS-1:0]       CLB_prgm_b,
    output logic                      prgm_b,
    output logic                      GWE,
    output logic [$clog2(NUM_LUTS):0] lut_idx,
    output logic                      done,
    output logic                      error
);
    localparam int IDX_W = $clog2(NUM_LUTS) + 1;
    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
`ifdef CFG_LOADER_PARITY_EN
        ST_CHECK = 3'd3,
`endif
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    // Running XOR of the emitted configuration bits.
    function automatic logic parity_acc(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction

    state_t               state_q, state_d;
    logic [7:0]           shreg_q, shreg_d;
    logic [2:0]           byte_bit_q, byte_bit_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]     lut_idx_q, lut_idx_d;
    logic                 parity_q, parity_d;
    logic                 byte_ready_q, byte_ready_d;
    logic                 config_data_out_q, config_data_out_d;
    logic                 shift_en_q, shift_en_d;
    logic [NUM_LUTS-1:0]  clb_prgm_b_q, clb_prgm_b_d;
    logic                 prgm_b_q, prgm_b_d;
    logic                 gwe_q, gwe_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    // Next-state, datapath and next-output computation.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        byte_bit_d = byte_bit_q;
        bit_cnt_d  = bit_cnt_q;
        lut_idx_d  = lut_idx_q;
        parity_d   = parity_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    lut_idx_d = '0;
                    bit_cnt_d = '0;
                    parity_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                if (bus.byte_valid && byte_ready_q) begin
                    shreg_d    = bus.byte_data;
                    byte_bit_d = 3'd0;
                    state_d    = ST_SHIFT;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_SHIFT: begin
                shreg_d    = {shreg_q[6:0], 1'b0};
                byte_bit_d = byte_bit_q + 3'd1;
                parity_d   = parity_acc(parity_q, shreg_q[7]);
                if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                    // Frame boundary: the next bit already belongs to the next
                    // LUT, even in the middle of a byte.
                    bit_cnt_d = '0;
                    lut_idx_d = lut_idx_q + IDX_W'(1);
                    if (lut_idx_q == IDX_W'(NUM_LUTS - 1)) begin
                        // Last bit of the last frame: leftover byte bits are dropped.
`ifdef CFG_LOADER_PARITY_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_DONE;
`endif
                    end else if (byte_bit_q == 3'd7) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (byte_bit_q == 3'd7) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
`ifdef CFG_LOADER_PARITY_EN
            ST_CHECK: begin
                if (bus.byte_valid && byte_ready_q) begin
                    if (bus.byte_data[0] == parity_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else begin
                    state_d = ST_CHECK;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are derived from the state being entered so the registered
        // copies are valid in the same cycle as that state.
`ifdef CFG_LOADER_PARITY_EN
        byte_ready_d = (state_d == ST_LOAD) || (state_d == ST_CHECK);
        error_d      = (state_d == ST_ERR);
`else
        byte_ready_d = (state_d == ST_LOAD);
        error_d      = 1'b0;
`endif
        shift_en_d = (state_d == ST_SHIFT);
        if (state_d == ST_SHIFT) begin
            config_data_out_d = shreg_d[7];
            clb_prgm_b_d      = NUM_LUTS'(1) << lut_idx_d;
        end else begin
            config_data_out_d = 1'b0;
            clb_prgm_b_d      = '0;
        end
        prgm_b_d = (state_d == ST_DONE);
        gwe_d    = (state_d == ST_DONE);
        done_d   = (state_d == ST_DONE);
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            shreg_q           <= 8'h00;
            byte_bit_q        <= 3'd0;
            bit_cnt_q         <= '0;
            lut_idx_q         <= '0;
            parity_q          <= 1'b0;
            byte_ready_q      <= 1'b0;
            config_data_out_q <= 1'b0;
            shift_en_q        <= 1'b0;
            clb_prgm_b_q      <= '0;
            prgm_b_q          <= 1'b0;
            gwe_q             <= 1'b0;
            done_q            <= 1'b0;
            error_q           <= 1'b0;
        end else begin
            state_q           <= state_d;
            shreg_q           <= shreg_d;
            byte_bit_q        <= byte_bit_d;
            bit_cnt_q         <= bit_cnt_d;
            lut_idx_q         <= lut_idx_d;
            parity_q          <= parity_d;
            byte_ready_q      <= byte_ready_d;
            config_data_out_q <= config_data_out_d;
            shift_en_q        <= shift_en_d;
            clb_prgm_b_q      <= clb_prgm_b_d;
            prgm_b_q          <= prgm_b_d;
            gwe_q             <= gwe_d;
            done_q            <= done_d;
            error_q           <= error_d;
        end
    end

    assign bus.byte_ready   = byte_ready_q;
    assign config_data_out  = config_data_out_q;
    assign shift_en         = shift_en_q;
    assign CLB_prgm_b       = clb_prgm_b_q;
    assign prgm_b           = prgm_b_q;
    assign GWE              = gwe_q;
    assign lut_idx          = lut_idx_q;
    assign done             = done_q;
    assign error            = error_q;
endmodule

// File: tb/tb_clb_config_loader.sv
// ----------------------------------------------------------------------------
// tb_clb_config_loader
// Two loader instances: a single-LUT chain and a four-LUT chain (38-bit
// frames). The expected serial stream is rebuilt from the bytes that were
// sent: bit n is bit (7 - n%8) of byte n/8, belonging to LUT n/38.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clb_config_loader;
    localparam int FB = 38;

    logic CLK    = 1'b0;
    logic reset  = 1'b1;
    logic start1 = 1'b0;
    logic start4 = 1'b0;

    always #5 CLK = ~CLK;

    clb_config_loader_if if1 ();
    clb_config_loader_if if4 ();

    logic       cdo1, se1, prgm1, gwe1, done1, err1;
    logic [0:0] clb1;
    logic [0:0] idx1;
    logic       cdo4, se4, prgm4, gwe4, done4, err4;
    logic [3:0] clb4;
    logic [2:0] idx4;

    clb_config_loader #(.NUM_LUTS(1), .FRAME_BITS(FB)) u1 (
        .CLK(CLK), .reset(reset), .start(start1), .bus(if1),
        .config_data_out(cdo1), .shift_en(se1), .CLB_prgm_b(clb1),
        .prgm_b(prgm1), .GWE(gwe1), .lut_idx(idx1), .done(done1), .error(err1)
    );

    clb_config_loader #(.NUM_LUTS(4), .FRAME_BITS(FB)) u4 (
        .CLK(CLK), .reset(reset), .start(start4), .bus(if4),
        .config_data_out(cdo4), .shift_en(se4), .CLB_prgm_b(clb4),
        .prgm_b(prgm4), .GWE(gwe4), .lut_idx(idx4), .done(done4), .error(err4)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last1  = 0;
    int last4  = 0;
    int gap_max = 0;
    logic       bits1[$];
    logic       bits4[$];
    logic [3:0] clbs1[$];
    logic [3:0] clbs4[$];
    logic [7:0] tx_q[$];
`ifdef CFG_LOADER_PARITY_EN
    bit par_bad = 1'b0;
    localparam int DONE_LAT = 2;
`else
    localparam int DONE_LAT = 1;
`endif

    typedef struct {
        logic [39:0] bytes;
        logic [37:0] exp_bits;
    } vec_t;
    vec_t vecs[4];

    always @(posedge CLK) cyc <= cyc + 1;

    // Serial monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        if (se1) begin
            bits1.push_back(cdo1);
            clbs1.push_back({3'b000, clb1});
            last1 <= cyc;
        end
        if (se4) begin
            bits4.push_back(cdo4);
            clbs4.push_back(clb4);
            last4 <= cyc;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int w);
        return (w == 1) ? if1.byte_ready : if4.byte_ready;
    endfunction

    function automatic logic done_of(input int w);
        return (w == 1) ? done1 : done4;
    endfunction

    function automatic logic err_of(input int w);
        return (w == 1) ? err1 : err4;
    endfunction

    function automatic logic model_bit(input int n);
        logic [7:0] b;
        b = tx_q[n / 8];
        return b[7 - (n % 8)];
    endfunction

    task automatic set_valid(input int w, input logic v, input logic [7:0] d);
        if (w == 1) begin
            if1.byte_valid = v;
            if1.byte_data  = d;
        end else begin
            if4.byte_valid = v;
            if4.byte_data  = d;
        end
    endtask

    task automatic pulse_start(input int w);
        if (w == 1) start1 = 1'b1;
        else        start4 = 1'b1;
        @(negedge CLK);
        start1 = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic send_byte(input int w, input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(negedge CLK);
        set_valid(w, 1'b1, d);
        for (int i = 0; i < 64; i++) begin
            if (rdy(w)) begin
                ok = 1'b1;
                @(negedge CLK);
                break;
            end
            @(negedge CLK);
        end
        set_valid(w, 1'b0, 8'h00);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_byte dut%0d: byte_ready never seen, byte=%0h", w, d);
        end
    endtask

    task automatic finish_load(input int w, input int nbits, output int done_cyc);
`ifdef CFG_LOADER_PARITY_EN
        logic p;
        p = 1'b0;
        for (int n = 0; n < nbits; n++) p = p ^ model_bit(n);
        send_byte(w, {7'b0101010, p ^ par_bad});
`endif
        done_cyc = -1;
        for (int i = 0; i < 200; i++) begin
            if (done_of(w) || err_of(w)) begin
                done_cyc = cyc;
                break;
            end
            @(negedge CLK);
        end
        if (done_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL finish_load dut%0d: no done/error within 200 cycles, bits=%0d", w, nbits);
        end
    endtask

    task automatic check_stream(input int w, input int nbits, input string name);
        int   nseen;
        int   bad_bits;
        int   bad_clb;
        logic b;
        logic [3:0] c;
        bad_bits = 0;
        bad_clb  = 0;
        nseen = (w == 1) ? bits1.size() : bits4.size();
        chk({name, " shift_en count"}, 64'(nseen), 64'(nbits));
        for (int n = 0; n < nseen && n < nbits; n++) begin
            b = (w == 1) ? bits1[n] : bits4[n];
            c = (w == 1) ? clbs1[n] : clbs4[n];
            if (b !== model_bit(n)) bad_bits++;
            if (c !== (4'b0001 << (n / FB))) bad_clb++;
        end
        chk({name, " serial bit errors"}, 64'(bad_bits), 64'd0);
        chk({name, " CLB_prgm_b errors"}, 64'(bad_clb), 64'd0);
    endtask

    task automatic check_done(input int w, input string name);
        if (w == 1)
            chk({name, " done state"}, {if1.byte_ready, se1, clb1, prgm1, gwe1, done1, err1}, 7'b0001110);
        else
            chk({name, " done state"}, {if4.byte_ready, se4, clb4, prgm4, gwe4, done4, err4}, 10'b0000001110);
    endtask

    initial begin
        int dc;
        int bad;
        logic [37:0] got;

        vecs[0] = '{40'hA53CFF00FC, 38'h294F3FC03F};
        vecs[1] = '{40'hFFFFFFFFFF, 38'h3FFFFFFFFF};
        vecs[2] = '{40'h0000000000, 38'h0000000000};
        vecs[3] = '{40'h0123456789, 38'h0048D159E2};

        set_valid(1, 1'b0, 8'h00);
        set_valid(4, 1'b0, 8'h00);
        repeat (3) @(negedge CLK);
        chk("reset outputs u1", {if1.byte_ready, se1, cdo1, clb1, prgm1, gwe1, done1, err1, idx1}, 64'd0);
        chk("reset outputs u4", {if4.byte_ready, se4, cdo4, clb4, prgm4, gwe4, done4, err4, idx4}, 64'd0);
        reset = 1'b0;
        @(negedge CLK);
        chk("idle byte_ready", {if1.byte_ready, if4.byte_ready}, 2'b00);

        // Reset in the middle of a load.
        pulse_start(1);
        send_byte(1, 8'hA5);
        send_byte(1, 8'h3C);
        repeat (3) @(negedge CLK);
        chk("mid-load shifting", {se1, prgm1}, 2'b10);
        #2 reset = 1'b1;
        #1;
        chk("reset mid-load outputs", {if1.byte_ready, se1, cdo1, clb1, prgm1, gwe1, done1, err1, idx1}, 64'd0);
        @(negedge CLK);
        reset = 1'b0;
        set_valid(1, 1'b1, 8'hFF);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (if1.byte_ready || se1) bad++;
        end
        set_valid(1, 1'b0, 8'h00);
        chk("post-reset no ready", 64'(bad), 64'd0);
        bits1.delete();
        clbs1.delete();

        // Table of single-LUT loads.
        for (int i = 0; i < 4; i++) begin
            tx_q.delete();
            for (int k = 0; k < 5; k++) tx_q.push_back(vecs[i].bytes[39 - 8 * k -: 8]);
            bits1.delete();
            clbs1.delete();
            pulse_start(1);
            for (int k = 0; k < 5; k++) send_byte(1, tx_q[k]);
            finish_load(1, FB, dc);
            got = '0;
            for (int n = 0; n < FB && n < bits1.size(); n++) got[37 - n] = bits1[n];
            chk($sformatf("vec%0d serial", i), 64'(got), 64'(vecs[i].exp_bits));
            check_stream(1, FB, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d done latency", i), 64'(dc - last1), 64'(DONE_LAT));
            check_done(1, $sformatf("vec%0d", i));
        end

        // DONE holds and ignores byte_valid.
        set_valid(1, 1'b1, 8'h77);
        repeat (4) @(negedge CLK);
        set_valid(1, 1'b0, 8'h00);
        check_done(1, "done hold");

        // Back-pressure in LOAD, with a stray start while shifting.
        tx_q.delete();
        tx_q = '{8'hC3, 8'h5A, 8'h96, 8'h0F, 8'hE1};
        bits1.delete();
        clbs1.delete();
        pulse_start(1);
        send_byte(1, tx_q[0]);
        start1 = 1'b1;
        @(negedge CLK);
        start1 = 1'b0;
        for (int i = 0; i < 20 && !if1.byte_ready; i++) @(negedge CLK);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!if1.byte_ready || se1) bad++;
            @(negedge CLK);
        end
        chk("backpressure hold", 64'(bad), 64'd0);
        for (int k = 1; k < 5; k++) send_byte(1, tx_q[k]);
        finish_load(1, FB, dc);
        check_stream(1, FB, "backpressure");
        check_done(1, "backpressure");

`ifdef CFG_LOADER_PARITY_EN
        // Inverted trailing parity bit, then a clean reload.
        tx_q.delete();
        for (int k = 0; k < 5; k++) tx_q.push_back(vecs[0].bytes[39 - 8 * k -: 8]);
        par_bad = 1'b1;
        bits1.delete();
        clbs1.delete();
        pulse_start(1);
        for (int k = 0; k < 5; k++) send_byte(1, tx_q[k]);
        finish_load(1, FB, dc);
        chk("parity bad outputs", {err1, prgm1, gwe1, done1}, 4'b1000);
        par_bad = 1'b0;
        bits1.delete();
        clbs1.delete();
        pulse_start(1);
        for (int k = 0; k < 5; k++) send_byte(1, tx_q[k]);
        finish_load(1, FB, dc);
        check_done(1, "parity recover");
`endif

        // Four LUTs, frame boundary crossing with 0x55.
        tx_q.delete();
        for (int k = 0; k < 19; k++) tx_q.push_back(8'h55);
        bits4.delete();
        clbs4.delete();
        pulse_start(4);
        for (int k = 0; k < 19; k++) send_byte(4, tx_q[k]);
        finish_load(4, 4 * FB, dc);
        check_stream(4, 4 * FB, "frame55");
        if (clbs4.size() >= 4 * FB) begin
            chk("clb bit38", {clbs4[37], clbs4[38]}, 8'h12);
            chk("clb bit77", {clbs4[75], clbs4[76]}, 8'h24);
            chk("clb bit115", {clbs4[113], clbs4[114]}, 8'h48);
        end
        check_done(4, "frame55");

        // Random bytes with random source gaps.
        gap_max = 3;
        for (int r = 0; r < 4; r++) begin
            tx_q.delete();
            for (int k = 0; k < 19; k++) tx_q.push_back(8'($urandom_range(0, 255)));
            bits4.delete();
            clbs4.delete();
            pulse_start(4);
            for (int k = 0; k < 19; k++) send_byte(4, tx_q[k]);
            finish_load(4, 4 * FB, dc);
            check_stream(4, 4 * FB, $sformatf("rand%0d", r));
            check_done(4, $sformatf("rand%0d", r));
        end
        gap_max = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/clb_config_loader.md
# clb_config_loader

Serial configuration sequencer that sits directly upstream of the SLICEM LUT blocks in a CLB. It accepts the configuration bitstream as bytes over a valid/ready handshake and serialises them MSB-first onto the LUT configuration shift chain. It also drives the per-LUT program-enable strobes and, once every frame is loaded, raises the global `prgm_b`/`GWE` to switch the CLB into operate mode.

## Interface
- `NUM_LUTS`, default 4: number of LUTs on the chain, programmed in index order 0..NUM_LUTS-1.
- `FRAME_BITS`, default 38: configuration bits per LUT (20 interconnect, 2 mux-select, 16 truth-table).

- `CLK` input 1: clock, rising edge.
- `reset` input 1: reset, asynchronous, active-high.
- `start` input 1: single-cycle pulse that begins a load.
- `byte_valid` input 1: `byte_data` is valid.
- `byte_data` input 8: bitstream byte, MSB is sent first.
- `byte_ready` output 1: loader can accept a byte.
- `config_data_out` output 1: serial bit to the LUT `config_data_in`.
- `shift_en` output 1: `config_data_out` is valid this cycle.
- `CLB_prgm_b` output NUM_LUTS: one-hot; bit i is high while LUT i is being shifted.
- `prgm_b` output 1: 0 while configuring, 1 in operate mode.
- `GWE` output 1: global write enable; follows `prgm_b`.
- `lut_idx` output $clog2(NUM_LUTS)+1: index of the current LUT.
- `done` output 1: load complete.
- `error` output 1: load failed (parity only).

## Operation
- FSM states: IDLE, LOAD, SHIFT, CHECK (parity builds only), DONE, ERR.
- IDLE
  - All outputs are low.
  - `start` moves the FSM to LOAD and clears `lut_idx`, the bit counter and the parity accumulator.
- LOAD
  - `byte_ready`=1.
  - When `byte_valid && byte_ready`, the byte is captured into the shift register and the FSM moves to SHIFT.
- SHIFT
  - Emits one bit per cycle for 8 cycles: `config_data_out`=shreg[7], `shift_en`=1, `CLB_prgm_b`=1<<`lut_idx`.
  - The frame bit counter increments on every emitted bit.
  - When the counter reaches FRAME_BITS-1, it wraps to 0 and `lut_idx` increments on the same edge. The next bit is the first bit of the next LUT, so frames are not byte-aligned.
  - After 8 bits the FSM returns to LOAD.
- When the final bit of LUT NUM_LUTS-1 is emitted:
  - Any remaining bits of the current byte are discarded; `shift_en` is 0 for them.
  - The FSM goes to CHECK (parity builds) or DONE.
- DONE
  - `prgm_b`=1, `GWE`=1, `done`=1, `CLB_prgm_b`=0.
  - The state holds until `start`, which clears `prgm_b` and `done` and re-enters LOAD.
- ERR
  - `error`=1; `prgm_b` and `GWE` stay 0.
  - Exits only on `start` (to LOAD) or `reset`.
- `start` in LOAD, SHIFT or CHECK is ignored.
- `byte_valid` outside LOAD is ignored; no byte is consumed.
- Total bytes per load = ceil(NUM_LUTS*FRAME_BITS/8), plus one byte in parity builds.

## Timing
- Reset value of every output is 0, including `lut_idx`. `reset` mid-load aborts immediately to IDLE.
- Byte accept edge → first `shift_en` on the next cycle.
- A full byte takes 8 SHIFT cycles plus 1 LOAD cycle: `byte_ready` reasserts in the cycle after the 8th bit, so peak throughput is 1 byte per 9 cycles.
- `CLB_prgm_b` changes on the same edge as the LUT boundary, so the first bit of LUT i+1 is presented with bit i+1 set.
- The last emitted bit → DONE (or CHECK) on the next edge. `prgm_b`, `GWE` and `done` rise together.

## Configuration
- `CFG_LOADER_PARITY_EN`
  - Defined:
    - The loader XORs every emitted configuration bit.
    - After the last frame it enters CHECK and accepts one further byte (`byte_ready`=1 in CHECK).
    - If that byte's bit0 equals the accumulated XOR, the FSM goes to DONE; otherwise it goes to ERR.
    - One extra cycle of latency is added before DONE.
  - Undefined: no CHECK state, no trailing byte, and `error` is tied to 0.

## Test plan
- Reset mid-load
  - Stimulus: NUM_LUTS=1; `start`, feed 2 bytes, pulse `reset`.
  - Required: all outputs 0 immediately; `byte_ready` stays 0 until the next `start`.
- Single LUT load
  - Stimulus: NUM_LUTS=1, FRAME_BITS=38; `start`, bytes 0xA5,0x3C,0xFF,0x00,0xFC.
  - Required: exactly 38 `shift_en` pulses; serial sequence is the MSB-first concatenation of the bytes truncated to 38 bits; the last 2 bits of 0xFC are suppressed; `prgm_b`=`done`=1 one cycle after bit 38.
- Frame boundary crossing
  - Stimulus: NUM_LUTS=4; stream 19 bytes of 0x55.
  - Required: `CLB_prgm_b` steps 0001→0010 at bit 39, 0100 at bit 77, 1000 at bit 115; 152 total pulses; `done` afterwards.
- Back-pressure
  - Stimulus: `byte_valid` held low for 5 cycles while in LOAD.
  - Required: `byte_ready` stays 1; no `shift_en`; the load resumes correctly afterwards.
- Parity (`CFG_LOADER_PARITY_EN`)
  - Stimulus: correct trailing bit, then a run with that bit inverted.
  - Required: first run reaches `done`=1; second run gives `error`=1 with `prgm_b`=0. A subsequent `start` with correct data reaches `done`.
